// File: rtl/pio_change_timer.sv
// Measures cycles from the first PIO bus change after arming to an FPGA-side stop event.
// Results are exposed on a zero-wait-state Avalon-MM slave; irq is derived from registered state.
module pio_change_timer #(
   parameter int          COUNT_W   = 32,
   parameter logic [31:0] PIO_RESET = 32'h000003FF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pio_in,
   input  logic        stop_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNTING, S_DONE} state_t;

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   logic [31:0]        pio_q;
   logic [31:0]        capture;
   logic [COUNT_W-1:0] count;
   logic [15:0]        runs;
   logic               overflow;
   logic               irq_en;

   logic wr, ctrl_wr, arm, clr, runs_wr, change;

   assign wr      = chipselect && !write_n;
   assign ctrl_wr = wr && (address == 2'd0);
   assign arm     = ctrl_wr && writedata[0];
   assign clr     = ctrl_wr && writedata[1];
   assign runs_wr = wr && (address == 2'd3);
   assign change  = (pio_in != pio_q);

   logic unused_wdata;
   assign unused_wdata = &{1'b0, writedata[31:5], writedata[3:2]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         pio_q    <= PIO_RESET;
         capture  <= '0;
         count    <= '0;
         runs     <= '0;
         overflow <= 1'b0;
         irq_en   <= 1'b0;
      end else begin
         pio_q <= pio_in;
         if (ctrl_wr)
            irq_en <= writedata[4];
         // An abort (arm while counting) must not count as a completed run.
         if (runs_wr)
            runs <= '0;
         else if (state == S_COUNTING && stop_in && !arm)
            runs <= runs + 16'd1;
         if (arm) begin
            state    <= S_ARMED;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            case (state)
               S_ARMED: begin
                  if (change) begin
                     state   <= S_COUNTING;
                     capture <= pio_in;
                     count   <= '0;
                  end
               end
               S_COUNTING: begin
                  if (count == CNT_MAX)
                     overflow <= 1'b1;
                  else
                     count <= count + 1'b1;
                  if (stop_in)
                     state <= S_DONE;
               end
               S_DONE: begin
                  if (clr)
                     state <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata = {27'b0, irq_en, overflow, (state == S_DONE),
                           (state == S_COUNTING), (state == S_ARMED)};
         2'd1: readdata[COUNT_W-1:0] = count;
         2'd2: readdata = capture;
         default: readdata = {16'b0, runs};
      endcase
   end

   assign irq = (state == S_DONE) && irq_en;

endmodule

// File: tb/tb_pio_change_timer.sv
// Drives a 32-bit and an 8-bit counter instance in lockstep; a scoreboard checks every read.
module tb_pio_change_timer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pio_in;
   logic        stop_in;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] rd32, rd8;
   logic        irq32, irq8;

   always #5 clk = ~clk;

   pio_change_timer #(.COUNT_W(32), .PIO_RESET(32'h3FF)) dut (
      .clk(clk), .reset_n(reset_n), .pio_in(pio_in), .stop_in(stop_in),
      .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd32), .irq(irq32));

   pio_change_timer #(.COUNT_W(8), .PIO_RESET(32'h3FF)) dut8 (
      .clk(clk), .reset_n(reset_n), .pio_in(pio_in), .stop_in(stop_in),
      .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd8), .irq(irq8));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: elapsed time is the edge distance from the change edge.
   typedef enum {M_IDLE, M_ARMED, M_COUNTING, M_DONE} mph_t;
   mph_t        ph;
   int unsigned t, chg_t, d;
   logic [31:0] m_prev, m_cap;
   int unsigned m_el32, m_el8, m_runs;
   bit          m_ov8, m_ien;
   bit          m_wr, m_ctrl, m_arm, m_clr, m_rwr;

   always @(posedge clk) begin
      t++;
      if (!reset_n) begin
         ph = M_IDLE; m_cap = 0; m_el32 = 0; m_el8 = 0; m_ov8 = 0;
         m_ien = 0; m_runs = 0; m_prev = 32'h3FF;
      end else begin
         m_wr   = chipselect && !write_n;
         m_ctrl = m_wr && address == 2'd0;
         m_arm  = m_ctrl && writedata[0];
         m_clr  = m_ctrl && writedata[1];
         m_rwr  = m_wr && address == 2'd3;
         if (m_ctrl) m_ien = writedata[4];
         if (m_rwr) m_runs = 0;
         else if (ph == M_COUNTING && stop_in && !m_arm) m_runs = (m_runs + 1) % 65536;
         if (m_arm) begin
            ph = M_ARMED; m_el32 = 0; m_el8 = 0; m_ov8 = 0;
         end else begin
            case (ph)
               M_ARMED: if (pio_in != m_prev) begin
                  ph = M_COUNTING; chg_t = t; m_cap = pio_in; m_el32 = 0; m_el8 = 0;
               end
               M_COUNTING: begin
                  d = t - chg_t;
                  m_el32 = d;
                  m_el8  = (d > 255) ? 255 : d;
                  m_ov8  = (d > 255);
                  if (stop_in) ph = M_DONE;
               end
               M_DONE: if (m_clr) ph = M_IDLE;
               default: ;
            endcase
         end
         m_prev = pio_in;
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] a, input bit w8);
      case (a)
         2'd0: return {27'b0, m_ien, (w8 ? m_ov8 : 1'b0), ph == M_DONE,
                       ph == M_COUNTING, ph == M_ARMED};
         2'd1: return w8 ? m_el8 : m_el32;
         2'd2: return m_cap;
         default: return {16'b0, m_runs[15:0]};
      endcase
   endfunction

   typedef struct {
      logic [1:0]  a;
      logic [31:0] e32;
      logic [31:0] e8;
      logic        irq;
   } exp_t;
   exp_t sb[$];
   bit   rd_vld = 0;
   logic [31:0] pio_cur = 32'h3FF;

   // Monitor: every presented read is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rd_vld) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("rd32 a%0d", e.a), rd32, e.e32);
            chk($sformatf("rd8 a%0d", e.a), rd8, e.e8);
            chk("irq32", {31'b0, irq32}, {31'b0, e.irq});
            chk("irq8", {31'b0, irq8}, {31'b0, e.irq});
         end
      end
   end

   task automatic rd_cycle(input logic [31:0] p, input logic s, input logic [1:0] a,
                           input bit use_c, input logic [31:0] c32, input logic [31:0] c8);
      exp_t e;
      pio_cur = p; pio_in = p; stop_in = s;
      chipselect = 1; write_n = 1; address = a; writedata = 0;
      e.a   = a;
      e.e32 = use_c ? c32 : model_rd(a, 0);
      e.e8  = use_c ? c8  : model_rd(a, 1);
      e.irq = (ph == M_DONE) && m_ien;
      sb.push_back(e);
      rd_vld = 1;
      @(posedge clk); #1;
      rd_vld = 0; chipselect = 0;
   endtask

   task automatic cyc(input logic [31:0] p, input logic s);
      rd_cycle(p, s, 2'($urandom_range(3)), 0, 0, 0);
   endtask

   task automatic rd_exp(input logic [1:0] a, input logic [31:0] c32, input logic [31:0] c8);
      rd_cycle(pio_cur, 0, a, 1, c32, c8);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] dat);
      pio_in = pio_cur; stop_in = 0;
      chipselect = 1; write_n = 0; address = a; writedata = dat;
      @(posedge clk); #1;
      chipselect = 0; write_n = 1;
   endtask

   initial begin
      reset_n = 0; pio_in = 32'h3FF; stop_in = 0; address = 0;
      chipselect = 0; write_n = 1; writedata = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;

      // Idle after reset: nothing armed, counting or counted.
      for (int i = 0; i < 10; i++) rd_exp(2'(i % 4), 0, 0);

      // Basic measurement with irq enabled.
      wr(0, 32'h11);
      cyc(32'h1, 0);
      for (int i = 0; i < 24; i++) cyc(32'h1, 0);
      cyc(32'h1, 1);
      rd_exp(1, 25, 25);
      rd_exp(2, 1, 1);
      rd_exp(0, 32'h14, 32'h14);
      rd_exp(3, 1, 1);

      // Stop held through ARMED and the change cycle gives the minimum result of 1.
      wr(0, 32'h01);
      for (int i = 0; i < 3; i++) cyc(32'h1, 1);
      cyc(32'h2, 1);
      cyc(32'h2, 1);
      rd_exp(1, 1, 1);
      rd_exp(0, 32'h04, 32'h04);

      // Long run: 8-bit instance saturates and flags overflow.
      wr(0, 32'h01);
      cyc(32'h3, 0);
      for (int i = 0; i < 300; i++) cyc(32'h3, 0);
      cyc(32'h3, 1);
      rd_exp(1, 301, 255);
      rd_exp(0, 32'h04, 32'h0C);
      rd_exp(3, 3, 3);

      // Abort mid-count, then a fresh measurement of 7.
      wr(0, 32'h01);
      cyc(32'h4, 0);
      for (int i = 0; i < 9; i++) cyc(32'h4, 0);
      wr(0, 32'h01);
      cyc(32'h5, 0);
      for (int i = 0; i < 6; i++) cyc(32'h5, 0);
      cyc(32'h5, 1);
      rd_exp(1, 7, 7);
      rd_exp(3, 4, 4);

      // Arm and clear together from DONE: arm wins.
      wr(0, 32'h03);
      rd_exp(0, 32'h01, 32'h01);
      rd_exp(1, 0, 0);

      // Reset mid-count discards everything; next change is ignored.
      cyc(32'h6, 0);
      for (int i = 0; i < 5; i++) cyc(32'h6, 0);
      reset_n = 0;
      cyc(32'h6, 0);
      reset_n = 1;
      for (int i = 0; i < 4; i++) rd_exp(2'(i), 0, 0);
      cyc(32'h7, 0);
      rd_exp(0, 0, 0);

      // Randomized traffic checked against the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(999);
         if (r < 30)
            wr(0, {27'b0, 1'($urandom_range(1)), 2'b0, 1'($urandom_range(1)), 1'b1});
         else if (r < 60)
            wr(0, {27'b0, 1'($urandom_range(1)), 3'b010});
         else if (r < 65)
            wr(2'($urandom_range(3, 1)), $urandom);
         else if (r < 67) begin
            reset_n = 0;
            cyc(pio_cur, 0);
            reset_n = 1;
         end else
            cyc(($urandom_range(4) == 0) ? $urandom : pio_cur, ($urandom_range(9) == 0));
      end

      @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pio_change_timer.md
# pio_change_timer

Cycle-accurate latency timer sitting directly downstream of the 32-bit LED/PIO output register in the ARM–FPGA timing path. It watches the PIO output bus. When armed, it detects the first cycle in which the bus value changes, which marks an HPS write landing in fabric. It then counts clock cycles until an FPGA-side `stop_in` event. The elapsed count, the captured PIO value and status are readable by the HPS over a small Avalon-MM slave with the same zero-wait-state read style as the PIO.

## Interface
- `COUNT_W`, 32: elapsed-counter width; legal range 8..32.
- `PIO_RESET`, 32'h000003FF: reset value of the internal PIO history register. It equals the upstream PIO reset value, so no change is seen after reset.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: reset is synchronous and active-low; sampled on the `clk` rising edge.
- `pio_in` in 32: PIO output bus from upstream.
- `stop_in` in 1: measurement stop event, level-sampled each cycle.
- `address` in 2: Avalon-MM word address.
- `chipselect` in 1: Avalon-MM select.
- `write_n` in 1: Avalon-MM write strobe, active-low.
- `writedata` in 32: Avalon-MM write data.
- `readdata` out 32: Avalon-MM read data, combinational from `address`.
- `irq` out 1: high while `done` = 1 and `irq_en` = 1.

## Operation
- Register map (word address):
  - 0 CTRL/STAT.
    - Read: {27'b0, irq_en, overflow, done, counting, armed}.
    - Write bit0 = 1: arm. Bit1 = 1: clear. Bit4 sets `irq_en`, written on every CTRL write.
  - 1 ELAPSED: zero-extended count, read-only.
  - 2 CAPTURE: `pio_in` value at the change cycle, read-only.
  - 3 RUNS: {16'b0, completed-measurement count}. 16-bit, wraps 0xFFFF→0. Write of any data clears it.
- A write is `chipselect && !write_n`. Writes to read-only addresses are ignored.
- `pio_q` <= `pio_in` every cycle, in all states. change = (`pio_in` != `pio_q`).
- FSM states: IDLE, ARMED, COUNTING, DONE.
  - IDLE: arm → ARMED. Arm clears `done`, `overflow` and ELAPSED.
  - ARMED: change → COUNTING. CAPTURE <= `pio_in`; count <= 0. `stop_in` is ignored in this state.
  - COUNTING, every cycle: count <= count+1, saturating at 2^COUNT_W−1. On saturation `overflow` <= 1 and counting continues, holding the value. If `stop_in` = 1: → DONE and RUNS increments.
  - DONE: `done` = 1. Clear → IDLE, `done` <= 0. Arm → ARMED.
- Arm in ARMED or COUNTING aborts and restarts at ARMED. RUNS does not increment.
- Arm and clear in the same write: arm wins.
- Further changes on `pio_in` during COUNTING or DONE are ignored. CAPTURE holds the first changed value.
- Status bits: `armed` = (state==ARMED); `counting` = (state==COUNTING).

## Timing
- All outputs and registers are zero after reset, except `pio_q` = PIO_RESET and state = IDLE.
- Reset asserted mid-measurement returns to IDLE on the next edge. No partial result is kept.
- Arm write at edge E: `armed` reads 1 after E. A change in the first cycle after E is detected.
- Change detected in cycle N: COUNTING from edge N+1.
- `stop_in` sampled high in cycle N+k (k ≥ 1) gives ELAPSED = k and DONE from edge N+k+1.
- `stop_in` high in the change cycle itself is ignored. The minimum result is 1.
- `irq` is registered-state-derived: high the cycle after entering DONE when `irq_en` = 1.
- Read latency 0: `readdata` reflects register state in the same cycle. A register written at edge E reads its new value from E onward.

## Test plan
- Reset then idle 10 cycles with `pio_in` = 0x3FF → CTRL reads 0, no spurious `armed`/`counting`, RUNS = 0.
- Arm; `pio_in` 0x3FF→0x1 at cycle N; `stop_in` pulse at N+25 → ELAPSED = 25, CAPTURE = 0x1, `done` = 1, RUNS = 1. With `irq_en` = 1, `irq` rises one cycle after DONE.
- `stop_in` held high before and during the change cycle → result 1, not 0. `stop_in` pulses while ARMED are ignored.
- COUNT_W = 8; change, no stop for 300 cycles, then stop → ELAPSED = 255, `overflow` = 1.
- Re-arm mid-COUNTING at cycle 10, then change and stop 7 cycles later → ELAPSED = 7, RUNS unchanged by the abort. Write CTRL = 0x3 in DONE → ARMED (arm wins).
- `reset_n` low for one cycle mid-COUNTING → state IDLE, ELAPSED = 0, CAPTURE = 0. The next change is ignored until armed.
